multi_clk_div: RTL and testbench
================================

Name: multi_clk_div

Overview:
- Multi-channel, parametrised clock-enable divider. Successor to the single-channel 8-bit divider.
- Adds per-channel enable, pulse or square output mode, glitch-free divisor updates at period boundaries, and a common phase-align (sync) input.
- Outputs are registered strobes or levels in the clk domain. They feed downstream clock enables and are never used as clocks.

Parameters:
- CHANNELS, 2, number of independent divider channels (>=1).
- WIDTH, 8, width of each divisor field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  CHANNELS  per-channel run enable.
- mode  input  CHANNELS  per-channel mode: 0 = pulse, 1 = square.
- div_count_in  input  CHANNELS*WIDTH  divisor N; channel i uses bits [i*WIDTH +: WIDTH].
- sync  input  1  restart all running channels in phase.
- div  output  CHANNELS  divided output per channel.
- tick  output  CHANNELS  one-cycle strobe at the first cycle of every period.

Behaviour:
- Reset: synchronous, active-high. Every channel goes IDLE with cnt=0, act_n=0, div=0, tick=0. Reset has the highest priority.
- Per-channel state: IDLE/RUN, cnt[WIDTH-1:0], act_n[WIDTH-1:0] (shadow of divisor), act_mode.
- All outputs are registered. The value shown below for cycle k is visible right after the edge that makes cnt=k.
- Period: cnt runs 0..act_n-1, then wraps. No intermediate state at wrap.
- Pulse mode output: div=1 only when cnt==0.
- Square mode output: div=1 when cnt < H, where H = act_n - (act_n>>1) (ceil N/2). So for odd N the high phase is one cycle longer.
- tick: tick=1 exactly when cnt==0 in RUN, in both modes.
- IDLE -> RUN: on an edge with en=1 and div_count_in != 0:
  - act_n <= input, act_mode <= mode, cnt <= 0;
  - div <= 1, tick <= 1 on that same edge.
- IDLE with en=1 and N==0: stays IDLE, outputs 0.
- RUN, normal: cnt <= cnt+1.
- RUN, wrap (cnt == act_n-1):
  - cnt <= 0; act_n and act_mode resample the inputs, so divisor/mode changes only take effect at a period boundary;
  - if the sampled N==0, go IDLE (div=0, tick=0) instead.
- RUN with en=0: go IDLE on that edge, div=0, tick=0. The period is truncated.
- sync=1: every channel that is RUN or about to start behaves as if a wrap occurred on that edge (cnt=0, resample N/mode, div=1, tick=1).
  - sync on an edge already at wrap has no extra effect.
  - IDLE channels with en=0 ignore sync.
- Priority: reset > en=0 > sync > wrap > increment.
- N=1: cnt stays 0; div=1 and tick=1 every cycle in both modes.
- N=2^WIDTH-1: cnt reaches the all-ones-minus-one value and wraps with no overflow. All arithmetic is WIDTH bits and unsigned.
- Channels are fully independent except for the shared sync.

Test Plan:
- Reset then en=1, N=5, mode=1 -> div sequence 1,1,1,0,0 repeating; tick high every 5th cycle, starting with the first RUN cycle.
- Same channel, mode=0, N=6 -> div=tick, one cycle high in every 6; change input to 7 mid-period -> current period still 6 cycles, next period 7.
- Two channels, N=4 square and N=3 pulse, then assert sync for 1 cycle mid-period -> both show tick=1 and div=1 on the next edge, then 1,1,0,0 and 1,0,0 realigned.
- en dropped mid-period with N=8 -> div=0 and tick=0 from the next edge; re-enable -> restarts at cnt=0 with div=1.
- N=1 -> div=1 constantly. N=0 at start -> stays IDLE, div=0. N set to 0 while running -> IDLE at the next wrap.
- Reset asserted for 1 cycle while running N=5 (mirrors the legacy bench pattern at 380 ns intervals) -> all outputs 0 on the reset edge; restart with the current N on the first edge after reset deasserts.

Source files
------------

// File: rtl/multi_clk_div_if.sv
// -----------------------------------------------------------------------------
// multi_clk_div_if
//   Bundle of the control and output signals of the multi-channel clock-enable
//   divider. The controller side (testbench or parent logic) uses the master
//   modport; the divider itself uses the slave modport.
//
//   Signals:
//     en           [CHANNELS]        per-channel run enable
//     mode         [CHANNELS]        per-channel mode, 0 = pulse, 1 = square
//     div_count_in [CHANNELS*WIDTH]  divisor N, channel i at [i*WIDTH +: WIDTH]
//     sync                           restart all running channels in phase
//     div          [CHANNELS]        registered divided output per channel
//     tick         [CHANNELS]        registered strobe on first cycle of period
// -----------------------------------------------------------------------------
interface multi_clk_div_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);

  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*WIDTH-1:0] div_count_in;
  logic                      sync;
  logic [CHANNELS-1:0]       div;
  logic [CHANNELS-1:0]       tick;

  modport master (
    output en,
    output mode,
    output div_count_in,
    output sync,
    input  div,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    input  div_count_in,
    input  sync,
    output div,
    output tick
  );

endinterface

// File: rtl/multi_clk_div.sv
// -----------------------------------------------------------------------------
// multi_clk_div
//   Multi-channel clock-enable divider. Each channel counts 0..N-1 and drives
//   either a one-cycle pulse (mode 0) or a square wave whose high phase is
//   ceil(N/2) cycles (mode 1). A tick strobe marks the first cycle of every
//   period. Divisor and mode are captured into shadow registers only at period
//   boundaries, so a change on the inputs never produces a runt period. A
//   shared sync input forces every running (or starting) channel to begin a
//   new period on the same edge. Outputs are clock enables, never clocks.
//
//   Ports:
//     clk    system clock, everything on the rising edge
//     reset  synchronous, active-high reset
//     bus    multi_clk_div_if slave modport (en, mode, div_count_in, sync in;
//            div, tick out)
// -----------------------------------------------------------------------------
module multi_clk_div #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic          clk,
  input  logic          reset,
  multi_clk_div_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Registered per-channel state.
  state_t              r_state  [CHANNELS];
  logic [WIDTH-1:0]    r_cnt    [CHANNELS];
  logic [WIDTH-1:0]    r_actN   [CHANNELS];
  logic [CHANNELS-1:0] r_actMode;
  logic [CHANNELS-1:0] r_div;
  logic [CHANNELS-1:0] r_tick;

  // Next-state values computed combinationally.
  state_t              w_stateNext   [CHANNELS];
  logic [WIDTH-1:0]    w_cntNext     [CHANNELS];
  logic [WIDTH-1:0]    w_actNNext    [CHANNELS];
  logic [CHANNELS-1:0] w_actModeNext;
  logic [CHANNELS-1:0] w_divNext;
  logic [CHANNELS-1:0] w_tickNext;

  // Divisor field for each channel, split out of the packed input bus.
  logic [WIDTH-1:0]    w_nIn [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_split
    assign w_nIn[g] = bus.div_count_in[g*WIDTH +: WIDTH];
  end

  // Next-state logic for every channel. The priority chain is en=0 first,
  // then sync, then the natural wrap, then a plain increment. Sync and wrap
  // share the same restart path: both resample divisor and mode, and a zero
  // divisor at that moment parks the channel in IDLE. The registered outputs
  // are derived from the next state so that div/tick become visible on the
  // same edge that moves cnt to the value they describe.
  always_comb begin
    w_actModeNext = r_actMode;
    w_divNext     = '0;
    w_tickNext    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_stateNext[i] = r_state[i];
      w_cntNext[i]   = r_cnt[i];
      w_actNNext[i]  = r_actN[i];

      case (r_state[i])
        IDLE: begin
          if (bus.en[i] && (w_nIn[i] != '0)) begin
            w_stateNext[i]   = RUN;
            w_cntNext[i]     = '0;
            w_actNNext[i]    = w_nIn[i];
            w_actModeNext[i] = bus.mode[i];
          end
        end
        RUN: begin
          if (!bus.en[i]) begin
            w_stateNext[i] = IDLE;
            w_cntNext[i]   = '0;
          end else if (bus.sync || (r_cnt[i] == r_actN[i] - ONE)) begin
            w_cntNext[i] = '0;
            if (w_nIn[i] == '0) begin
              w_stateNext[i] = IDLE;
            end else begin
              w_actNNext[i]    = w_nIn[i];
              w_actModeNext[i] = bus.mode[i];
            end
          end else begin
            w_cntNext[i] = r_cnt[i] + ONE;
          end
        end
        default: begin
          w_stateNext[i] = IDLE;
          w_cntNext[i]   = '0;
        end
      endcase

      // Square high phase is N - floor(N/2), i.e. ceil(N/2), all in WIDTH bits.
      w_tickNext[i] = (w_stateNext[i] == RUN) && (w_cntNext[i] == '0);
      w_divNext[i]  = (w_stateNext[i] == RUN) &&
                      (w_actModeNext[i]
                         ? (w_cntNext[i] < (w_actNNext[i] - (w_actNNext[i] >> 1)))
                         : (w_cntNext[i] == '0));
    end
  end

  // State register. Reset wins over everything and returns every channel to
  // IDLE with cleared counters, shadows and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
        r_actN[i]  <= '0;
      end
      r_actMode <= '0;
      r_div     <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= w_stateNext[i];
        r_cnt[i]   <= w_cntNext[i];
        r_actN[i]  <= w_actNNext[i];
      end
      r_actMode <= w_actModeNext;
      r_div     <= w_divNext;
      r_tick    <= w_tickNext;
    end
  end

  assign bus.div  = r_div;
  assign bus.tick = r_tick;

endmodule

// File: tb/tb_multi_clk_div.sv
// -----------------------------------------------------------------------------
// tb_multi_clk_div
//   Self-checking bench for multi_clk_div with two 8-bit channels. Each
//   scenario task drives the inputs for one edge at a time, pushes the
//   expected div/tick pair for that edge onto a scoreboard queue, advances the
//   clock and pops/compares against the registered outputs.
// -----------------------------------------------------------------------------
module tb_multi_clk_div;

  localparam int CH = 2;
  localparam int W  = 8;

  typedef struct packed {
    logic [CH-1:0] div;
    logic [CH-1:0] tick;
  } exp_t;

  logic clk;
  logic reset;

  multi_clk_div_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  multi_clk_div #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sbQ[$];
  int   checks = 0;
  int   passes = 0;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyDivisor(input int ch, input int n);
    bus.div_count_in[ch*W +: W] = W'(n);
  endtask

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  // Reset held: everything must read zero.
  task automatic test_reset;
    exp_t e, got;
    for (int c = 0; c < 3; c++) begin
      reset = 1'b1;
      e.div = 2'b00; e.tick = 2'b00;
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL reset cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // Channel 0, square, N=5: 1,1,1,0,0 with tick on the first cycle.
  task automatic test_square;
    exp_t e, got;
    int k;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin
        reset = 1'b0; bus.en = 2'b01; bus.mode = 2'b01; applyDivisor(0, 5);
      end
      k = c % 5;
      e.div  = {1'b0, k < 3};
      e.tick = {1'b0, k == 0};
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL square5 cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // Switch to pulse N=6 at the boundary, then request N=7 mid-period:
  // the running period must still last 6 cycles.
  task automatic test_pulse_change;
    exp_t e, got;
    logic p;
    for (int c = 0; c < 27; c++) begin
      if (c == 0) begin
        bus.mode = 2'b00; applyDivisor(0, 6);
      end
      if (c == 15) applyDivisor(0, 7);
      p = (c < 18) ? ((c % 6) == 0) : (((c - 18) % 7) == 0);
      e.div  = {1'b0, p};
      e.tick = {1'b0, p};
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL pulse_change cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // Two channels (square N=4, pulse N=3), one-cycle sync mid-period.
  task automatic test_sync;
    exp_t e, got;
    int k;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) bus.en = 2'b00;
      if (c == 1) begin
        bus.en = 2'b11; bus.mode = 2'b01; applyDivisor(0, 4); applyDivisor(1, 3);
      end
      if (c == 12) bus.sync = 1'b1;
      if (c == 13) bus.sync = 1'b0;
      if (c == 0) begin
        e.div = 2'b00; e.tick = 2'b00;
      end else begin
        k = (c >= 12) ? c - 12 : c - 1;
        e.div  = {(k % 3) == 0, (k % 4) < 2};
        e.tick = {(k % 3) == 0, (k % 4) == 0};
      end
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL sync cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // Square N=8, enable dropped mid-period, then re-enabled.
  task automatic test_en_drop;
    exp_t e, got;
    int k;
    for (int c = 0; c < 18; c++) begin
      if (c == 0) begin
        bus.en = 2'b01; bus.mode = 2'b01; applyDivisor(0, 8);
      end
      if (c == 5) bus.en = 2'b00;
      if (c == 8) bus.en = 2'b01;
      if (c >= 5 && c < 8) begin
        e.div = 2'b00; e.tick = 2'b00;
      end else begin
        k = (c >= 8) ? c - 8 : c;
        e.div  = {1'b0, (k % 8) < 4};
        e.tick = {1'b0, (k % 8) == 0};
      end
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL en_drop cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // N=1 on both channels in both modes: constant high div and tick.
  task automatic test_n_one;
    exp_t e, got;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) bus.en = 2'b00;
      if (c == 1) begin
        bus.en = 2'b11; bus.mode = 2'b01; applyDivisor(0, 1); applyDivisor(1, 1);
      end
      e.div  = (c == 0) ? 2'b00 : 2'b11;
      e.tick = (c == 0) ? 2'b00 : 2'b11;
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL n_one cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // N=0 at start stays idle; N=0 while running idles at the next wrap.
  task automatic test_n_zero;
    exp_t e, got;
    int k;
    for (int c = 0; c < 13; c++) begin
      if (c == 0) bus.en = 2'b00;
      if (c == 1) begin
        bus.en = 2'b11; applyDivisor(0, 0); applyDivisor(1, 0);
      end
      if (c == 5) begin
        bus.mode = 2'b01; applyDivisor(0, 3);
      end
      if (c == 9) applyDivisor(0, 0);
      if (c >= 5 && c <= 10) begin
        k = c - 5;
        e.div  = {1'b0, (k % 3) < 2};
        e.tick = {1'b0, (k % 3) == 0};
      end else begin
        e.div = 2'b00; e.tick = 2'b00;
      end
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL n_zero cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // N=255 on both channels: counter reaches 254 and wraps cleanly.
  task automatic test_max;
    exp_t e, got;
    int k;
    for (int c = 0; c < 257; c++) begin
      if (c == 0) begin
        bus.mode = 2'b01; applyDivisor(0, 255); applyDivisor(1, 255);
      end
      k = c % 255;
      e.div  = {k == 0, k < 128};
      e.tick = {k == 0, k == 0};
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL max cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  // One-cycle reset in the middle of a square N=5 run (38 cycles in).
  task automatic test_reset_midrun;
    exp_t e, got;
    int k;
    for (int c = 0; c < 50; c++) begin
      if (c == 0) reset = 1'b1;
      if (c == 1) begin
        reset = 1'b0; bus.en = 2'b01; bus.mode = 2'b01; applyDivisor(0, 5);
      end
      if (c == 39) reset = 1'b1;
      if (c == 40) reset = 1'b0;
      if (c == 0 || c == 39) begin
        e.div = 2'b00; e.tick = 2'b00;
      end else begin
        k = (c < 39) ? c - 1 : c - 40;
        e.div  = {1'b0, (k % 5) < 3};
        e.tick = {1'b0, (k % 5) == 0};
      end
      sbQ.push_back(e);
      stepClock();
      got = sbQ.pop_front();
      checks++;
      if (bus.div !== got.div || bus.tick !== got.tick)
        $display("[TB] FAIL reset_midrun cycle %0d: div=%b tick=%b, expected div=%b tick=%b",
                 c, bus.div, bus.tick, got.div, got.tick);
      else passes++;
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.en           = '0;
    bus.mode         = '0;
    bus.div_count_in = '0;
    bus.sync         = 1'b0;

    test_reset();
    test_square();
    test_pulse_change();
    test_sync();
    test_en_drop();
    test_n_one();
    test_n_zero();
    test_max();
    test_reset_midrun();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
